// File: rtl/multi_channel_capture_pkg.sv
// Shared types and defaults for the multi-channel capture core.
package multi_channel_capture_pkg;

  localparam int unsigned DefNchan = 4;
  localparam int unsigned DefSize  = 12;
  localparam int unsigned DefWidth = 12;

  typedef enum logic [2:0] {
    StIdle,
    StPretrig,
    StArmed,
    StPost,
    StDone,
    StReadout
  } state_e;

  // Channel index width; a single channel still gets a 1-bit index.
  function automatic int unsigned chan_width(input int unsigned nchan);
    return (nchan > 1) ? $clog2(nchan) : 1;
  endfunction

endpackage

// File: rtl/capture_ringbuf.sv
// Simple dual-port sample RAM, one write port and one registered read port.
module capture_ringbuf
  import multi_channel_capture_pkg::*;
#(
  parameter int unsigned SIZE  = DefSize,
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [SIZE-1:0]  wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [SIZE-1:0]  rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [2**SIZE];

  // Read data holds while rd_en_i is low; the readout stall relies on this.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/multi_channel_capture.sv
// N-channel pre/post-trigger capture with a shared sequencer and back-pressured readout.
module multi_channel_capture
  import multi_channel_capture_pkg::*;
#(
  parameter int unsigned NCHAN = DefNchan,
  parameter int unsigned SIZE  = DefSize,
  parameter int unsigned WIDTH = DefWidth,
  localparam int unsigned CHW  = chan_width(NCHAN)
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   arm_i,
  input  logic                   trigger_i,
  input  logic                   sample_valid_i,
  input  logic [NCHAN*WIDTH-1:0] samples_i,
  input  logic [SIZE-1:0]        pre_samples_i,
  input  logic [SIZE-1:0]        post_samples_i,
  input  logic                   read_request_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   trig_missed_o,
  output logic [SIZE-1:0]        trig_addr_o,
  output logic                   ro_valid_o,
  input  logic                   ro_ready_i,
  output logic [WIDTH-1:0]       ro_data_o,
  output logic [CHW-1:0]         ro_chan_o,
  output logic                   ro_last_o
);

  localparam logic [SIZE:0] BufWords = {1'b1, {SIZE{1'b0}}};

  state_e          state_q, state_d;
  logic [SIZE-1:0] wp_q, wp_d;
  logic [SIZE-1:0] pre_q, pre_d, post_q, post_d;
  logic [SIZE-1:0] fill_q, fill_d, post_cnt_q, post_cnt_d;
  logic [SIZE-1:0] trig_addr_q, trig_addr_d;
  logic            trig_missed_q, trig_missed_d;
  logic [SIZE:0]   iss_idx_q, iss_idx_d;
  logic [CHW-1:0]  iss_chan_q, iss_chan_d;
  logic            iss_done_q, iss_done_d;
  logic            rd_valid_q, rd_valid_d;
  logic [CHW-1:0]  rd_chan_q, rd_chan_d;
  logic            rd_last_q, rd_last_d;

  logic            wr_en, issue, iss_last, accept, final_word;
  logic [SIZE:0]   win_sum, win_len;
  logic [SIZE-1:0] win_start, rd_addr;
  logic [WIDTH-1:0] rd_data [NCHAN];

  assign win_sum   = {1'b0, pre_q} + {1'b0, post_q};
  assign win_len   = (win_sum > BufWords) ? BufWords : win_sum;
  assign win_start = trig_addr_q - pre_q;
  assign rd_addr   = win_start + iss_idx_q[SIZE-1:0];

  assign iss_last   = (iss_idx_q == win_len - 1'b1);
  assign accept     = rd_valid_q && ro_ready_i;
  assign final_word = accept && rd_last_q && (rd_chan_q == CHW'(NCHAN - 1));
  // Issue a read only when the RAM output word is empty or being consumed this cycle.
  assign issue      = (state_q == StReadout) && !iss_done_q && (!rd_valid_q || ro_ready_i);

  always_comb begin
    state_d       = state_q;
    wp_d          = wp_q;
    pre_d         = pre_q;
    post_d        = post_q;
    fill_d        = fill_q;
    post_cnt_d    = post_cnt_q;
    trig_addr_d   = trig_addr_q;
    trig_missed_d = trig_missed_q;
    iss_idx_d     = iss_idx_q;
    iss_chan_d    = iss_chan_q;
    iss_done_d    = iss_done_q;
    rd_valid_d    = rd_valid_q;
    rd_chan_d     = rd_chan_q;
    rd_last_d     = rd_last_q;
    wr_en         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arm_i) begin
          pre_d         = pre_samples_i;
          post_d        = post_samples_i;
          fill_d        = '0;
          trig_missed_d = 1'b0;
          state_d       = StPretrig;
        end
      end
      StPretrig: begin
        if (trigger_i) trig_missed_d = 1'b1;
        wr_en = sample_valid_i;
        if (sample_valid_i) fill_d = fill_q + 1'b1;
        if ((fill_q == pre_q) || (sample_valid_i && (fill_d == pre_q))) state_d = StArmed;
      end
      StArmed: begin
        // The trigger-cycle sample belongs to the post window, so it is dropped when post is 0.
        wr_en = sample_valid_i && (!trigger_i || (post_q != '0));
        if (trigger_i) begin
          trig_addr_d = wp_q;
          post_cnt_d  = SIZE'(wr_en);
          state_d     = StPost;
        end
      end
      StPost: begin
        if (post_cnt_q == post_q) begin
          state_d = StDone;
        end else begin
          wr_en = sample_valid_i;
          if (sample_valid_i) post_cnt_d = post_cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (read_request_i) begin
          if (win_len == '0) begin
            state_d = StIdle;
          end else begin
            state_d    = StReadout;
            iss_idx_d  = '0;
            iss_chan_d = '0;
            iss_done_d = 1'b0;
            rd_valid_d = 1'b0;
          end
        end
      end
      StReadout: begin
        if (issue) begin
          rd_valid_d = 1'b1;
          rd_chan_d  = iss_chan_q;
          rd_last_d  = iss_last;
          if (iss_last) begin
            iss_idx_d = '0;
            if (iss_chan_q == CHW'(NCHAN - 1)) iss_done_d = 1'b1;
            else iss_chan_d = iss_chan_q + 1'b1;
          end else begin
            iss_idx_d = iss_idx_q + 1'b1;
          end
        end else if (accept) begin
          rd_valid_d = 1'b0;
        end
        if (final_word) begin
          rd_valid_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (wr_en) wp_d = wp_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= StIdle;
      wp_q          <= '0;
      pre_q         <= '0;
      post_q        <= '0;
      fill_q        <= '0;
      post_cnt_q    <= '0;
      trig_addr_q   <= '0;
      trig_missed_q <= 1'b0;
      iss_idx_q     <= '0;
      iss_chan_q    <= '0;
      iss_done_q    <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_chan_q     <= '0;
      rd_last_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wp_q          <= wp_d;
      pre_q         <= pre_d;
      post_q        <= post_d;
      fill_q        <= fill_d;
      post_cnt_q    <= post_cnt_d;
      trig_addr_q   <= trig_addr_d;
      trig_missed_q <= trig_missed_d;
      iss_idx_q     <= iss_idx_d;
      iss_chan_q    <= iss_chan_d;
      iss_done_q    <= iss_done_d;
      rd_valid_q    <= rd_valid_d;
      rd_chan_q     <= rd_chan_d;
      rd_last_q     <= rd_last_d;
    end
  end

  for (genvar k = 0; k < NCHAN; k++) begin : g_chan
    capture_ringbuf #(
      .SIZE  (SIZE),
      .WIDTH (WIDTH)
    ) u_buf (
      .clk_i     (clk_i),
      .wr_en_i   (wr_en),
      .wr_addr_i (wp_q),
      .wr_data_i (samples_i[k*WIDTH +: WIDTH]),
      .rd_en_i   (issue),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_data[k])
    );
  end

  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StDone);
  assign trig_missed_o = trig_missed_q;
  assign trig_addr_o   = trig_addr_q;
  assign ro_valid_o    = rd_valid_q;
  // RAM output is not reset, so gate it to keep idle outputs at zero.
  assign ro_data_o     = rd_valid_q ? rd_data[rd_chan_q] : '0;
  assign ro_chan_o     = rd_valid_q ? rd_chan_q : '0;
  assign ro_last_o     = rd_valid_q && rd_last_q;

endmodule

// File: tb/tb_multi_channel_capture.sv
// Randomised bench for multi_channel_capture against a window-level capture model.
module tb_multi_channel_capture;

  localparam int NCH = 2;
  localparam int SZ  = 4;
  localparam int WD  = 12;
  localparam int BUF = 16;

  logic              clk_i = 1'b0;
  logic              reset_ni;
  logic              arm_i, trigger_i, sample_valid_i, read_request_i, ro_ready_i;
  logic [NCH*WD-1:0] samples_i;
  logic [SZ-1:0]     pre_samples_i, post_samples_i;
  logic              busy_o, done_o, trig_missed_o, ro_valid_o, ro_last_o;
  logic [SZ-1:0]     trig_addr_o;
  logic [WD-1:0]     ro_data_o;
  logic [0:0]        ro_chan_o;

  int checks = 0;
  int errors = 0;

  // Model: every write since reset is recorded by the cycle stamp that produced it.
  int whist[$];
  int stamp = 0;
  int mphase = 0;  // 0 idle, 1 pre-fill, 2 armed, 3 post, 4 done
  int mpre, mpost, mfill, mpcnt, mT;
  bit mmissed = 0;

  always #5 clk_i = ~clk_i;

  multi_channel_capture #(
    .NCHAN (NCH),
    .SIZE  (SZ),
    .WIDTH (WD)
  ) dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .arm_i          (arm_i),
    .trigger_i      (trigger_i),
    .sample_valid_i (sample_valid_i),
    .samples_i      (samples_i),
    .pre_samples_i  (pre_samples_i),
    .post_samples_i (post_samples_i),
    .read_request_i (read_request_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .trig_missed_o  (trig_missed_o),
    .trig_addr_o    (trig_addr_o),
    .ro_valid_o     (ro_valid_o),
    .ro_ready_i     (ro_ready_i),
    .ro_data_o      (ro_data_o),
    .ro_chan_o      (ro_chan_o),
    .ro_last_o      (ro_last_o)
  );

  function automatic logic [WD-1:0] val(input int ch, input int s);
    return WD'((ch * 16 + s) % 4096);
  endfunction

  function automatic bit rnd(input int pct);
    return $urandom_range(99, 0) < pct;
  endfunction

  task automatic model_edge();
    case (mphase)
      0: if (arm_i) begin
        mpre = int'(pre_samples_i); mpost = int'(post_samples_i);
        mfill = 0; mmissed = 0; mphase = 1;
      end
      1: begin
        if (trigger_i) mmissed = 1;
        if (sample_valid_i) begin whist.push_back(stamp); mfill++; end
        if (mfill >= mpre) mphase = 2;
      end
      2: if (trigger_i) begin
        mT = whist.size(); mpcnt = 0; mphase = 3;
        if (sample_valid_i && mpost > 0) begin whist.push_back(stamp); mpcnt = 1; end
      end else if (sample_valid_i) begin
        whist.push_back(stamp);
      end
      3: if (mpcnt == mpost) mphase = 4;
         else if (sample_valid_i) begin whist.push_back(stamp); mpcnt++; end
      default: ;
    endcase
  endtask

  task automatic cycle(input bit v, input bit t, input bit a);
    sample_valid_i = v; trigger_i = t; arm_i = a;
    for (int ch = 0; ch < NCH; ch++) samples_i[ch*WD +: WD] = val(ch, stamp);
    @(posedge clk_i);
    model_edge();
    stamp++;
    #1;
    sample_valid_i = 0; trigger_i = 0; arm_i = 0;
  endtask

  task automatic capture(input int pre, input int post, input int armed_wait, input int vpct,
                         input bit trig_noise, input bit arm_noise);
    int budget;
    bit first;
    pre_samples_i  = SZ'(pre);
    post_samples_i = SZ'(post);
    cycle(1'b1, trig_noise, 1'b1);
    checks++;
    if (trig_missed_o !== 1'b0) begin
      errors++; $display("FAIL arm_clears_missed: got %0b want 0", trig_missed_o);
    end
    budget = 0; first = 1;
    while (mphase == 1 && budget < 500) begin
      cycle((mpre != 0) && rnd(vpct), trig_noise && (first || rnd(40)), 1'b0);
      first = 0; budget++;
    end
    for (int i = 0; i < armed_wait; i++) cycle(rnd(vpct), 1'b0, arm_noise);
    checks++;
    if ({busy_o, done_o} !== 2'b10 || mphase != 2) begin
      errors++; $display("FAIL wait_for_trigger: busy/done %b%b want 10", busy_o, done_o);
    end
    cycle(rnd(vpct), 1'b1, 1'b0);
    budget = 0;
    while (mphase != 4 && budget < 500) begin cycle(rnd(vpct), 1'b0, 1'b0); budget++; end
    checks++;
    if (done_o !== 1'b1) begin
      errors++; $display("FAIL done_reached: got %0b want 1", done_o);
    end
    checks++;
    if (trig_addr_o !== SZ'(mT % BUF)) begin
      errors++; $display("FAIL trig_addr: got %0d want %0d", trig_addr_o, mT % BUF);
    end
    checks++;
    if (trig_missed_o !== mmissed) begin
      errors++; $display("FAIL trig_missed: got %0b want %0b", trig_missed_o, mmissed);
    end
  endtask

  task automatic readout(input int ready_pct, input int abort_at);
    int len, total, got, iters, ch, k, g, nw, j;
    bit stalled, aborted, seen;
    logic [WD-1:0] sd, exp_d;
    logic [0:0] sc;
    logic sl;
    len = (mpre + mpost > BUF) ? BUF : mpre + mpost;
    total = NCH * len; got = 0; iters = 0; stalled = 0; aborted = 0; seen = 0;
    sd = '0; sc = '0; sl = 0;
    read_request_i = 1;
    @(posedge clk_i); #1;
    read_request_i = 0;
    if (len == 0) begin
      checks++;
      if (busy_o !== 1'b0) begin
        errors++; $display("FAIL empty_window_idle: busy %0b want 0", busy_o);
      end
      repeat (4) begin
        if (ro_valid_o !== 1'b0) seen = 1;
        @(posedge clk_i); #1;
      end
      checks++;
      if (seen !== 1'b0) begin
        errors++; $display("FAIL empty_window_valid: ro_valid rose, want 0");
      end
      mphase = 0;
      return;
    end
    checks++;
    if (ro_valid_o !== 1'b0) begin
      errors++; $display("FAIL latency_early: ro_valid %0b want 0", ro_valid_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if (ro_valid_o !== 1'b1) begin
      errors++; $display("FAIL latency_two: ro_valid %0b want 1", ro_valid_o);
    end
    while (got < total && iters < 4000 && !aborted) begin
      if (abort_at >= 0 && got == abort_at) begin
        ro_ready_i = 0;
        #2; reset_ni = 0; #1;
        checks++;
        if ({busy_o, done_o, trig_missed_o, trig_addr_o, ro_valid_o, ro_data_o, ro_chan_o,
             ro_last_o} !== '0) begin
          errors++;
          $display("FAIL reset_outputs: busy%0b done%0b miss%0b ta%0d v%0b d%0h c%0d l%0b want 0",
                   busy_o, done_o, trig_missed_o, trig_addr_o, ro_valid_o, ro_data_o,
                   ro_chan_o, ro_last_o);
        end
        whist.delete(); mphase = 0; mmissed = 0;
        @(posedge clk_i); #1;
        reset_ni = 1;
        aborted = 1;
      end else begin
        if (stalled) begin
          checks++;
          if ({ro_valid_o, ro_data_o, ro_chan_o, ro_last_o} !== {1'b1, sd, sc, sl}) begin
            errors++;
            $display("FAIL stall_hold: got v%0b d%0h c%0d l%0b want v1 d%0h c%0d l%0b",
                     ro_valid_o, ro_data_o, ro_chan_o, ro_last_o, sd, sc, sl);
          end
        end
        ro_ready_i = rnd(ready_pct);
        stalled = 0;
        if (ro_valid_o === 1'b1 && ro_ready_i) begin
          ch = got / len; k = got % len;
          g = mT - mpre + k;
          nw = whist.size();
          j = nw - 1 - ((nw - 1 - g) % BUF);
          exp_d = val(ch, whist[j]);
          checks++;
          if (ro_data_o !== exp_d) begin
            errors++; $display("FAIL word_data[%0d]: got %0h want %0h", got, ro_data_o, exp_d);
          end
          checks++;
          if ({ro_chan_o, ro_last_o} !== {1'(ch), (k == len - 1)}) begin
            errors++;
            $display("FAIL word_tag[%0d]: chan %0d last %0b want chan %0d last %0b",
                     got, ro_chan_o, ro_last_o, ch, (k == len - 1));
          end
          got++;
        end else if (ro_valid_o === 1'b1) begin
          stalled = 1; sd = ro_data_o; sc = ro_chan_o; sl = ro_last_o;
        end
        @(posedge clk_i); #1;
        iters++;
      end
    end
    ro_ready_i = 0;
    if (aborted) return;
    checks++;
    if (got != total) begin
      errors++; $display("FAIL readout_count: got %0d words want %0d", got, total);
    end
    if (ready_pct >= 100) begin
      checks++;
      if (iters != total) begin
        errors++; $display("FAIL throughput: %0d cycles want %0d", iters, total);
      end
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL readout_end_idle: busy %0b want 0", busy_o);
    end
    mphase = 0;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy_o, done_o, trig_missed_o, trig_addr_o} !== '0) begin
      errors++; $display("FAIL reset_status: busy%0b done%0b miss%0b ta%0d want 0",
                         busy_o, done_o, trig_missed_o, trig_addr_o);
    end
    checks++;
    if ({ro_valid_o, ro_data_o, ro_chan_o, ro_last_o} !== '0) begin
      errors++; $display("FAIL reset_readout: v%0b d%0h c%0d l%0b want 0",
                         ro_valid_o, ro_data_o, ro_chan_o, ro_last_o);
    end
  endtask

  task automatic test_basic();
    capture(3, 5, 7, 100, 1'b0, 1'b0);
    readout(100, -1);
  endtask

  task automatic test_wrap();
    capture(12, 8, 6, 100, 1'b0, 1'b0);
    readout(100, -1);
  endtask

  task automatic test_missed();
    capture(6, 3, 5, 70, 1'b1, 1'b1);
    readout(60, -1);
    capture(2, 2, 1, 100, 1'b0, 1'b0);
    readout(100, -1);
  endtask

  task automatic test_random_ready();
    for (int i = 0; i < 5; i++) begin
      capture($urandom_range(10, 0), $urandom_range(10, 1), $urandom_range(6, 0),
              $urandom_range(100, 50), 1'($urandom_range(1, 0)), 1'b0);
      readout(50, -1);
    end
  endtask

  task automatic test_zero();
    capture(0, 0, 3, 100, 1'b0, 1'b0);
    readout(100, -1);
    capture(4, 0, 2, 100, 1'b0, 1'b0);
    readout(70, -1);
  endtask

  task automatic test_reset_mid();
    capture(3, 5, 4, 100, 1'b0, 1'b0);
    readout(40, 5);
    test_reset();
    capture(5, 6, 3, 80, 1'b0, 1'b0);
    readout(80, -1);
  endtask

  initial begin
    reset_ni = 0; arm_i = 0; trigger_i = 0; sample_valid_i = 0; read_request_i = 0;
    ro_ready_i = 0; samples_i = '0; pre_samples_i = '0; post_samples_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    test_reset();
    reset_ni = 1;
    test_basic();
    test_wrap();
    test_missed();
    test_random_ready();
    test_zero();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_channel_capture.md
# multi_channel_capture

Parametrised N-channel capture core for the digitizer. It takes frame-aligned, already-deserialised ADC samples from NCHAN lvds receivers into per-channel ring buffers and holds a programmable pre-trigger window while armed. On trigger it records a programmable post-trigger window, then streams the captured windows out, channel by channel, over a valid/ready interface. It replaces the per-channel ring buffer, state machine and address controller trio with one shared sequencer and adds a guaranteed pre-trigger fill and a back-pressured readout.

## Interface
- NCHAN, 4, number of ADC channels (≥1)
- SIZE, 12, address bits; each channel buffer holds 2^SIZE samples
- WIDTH, 12, sample width
- CHW, derived, max(1, clog2(NCHAN)); not user-set
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- arm  in  1  single-cycle pulse that starts a capture; honoured only in IDLE
- trigger  in  1  level trigger, sampled each cycle
- sample_valid  in  1  all channels present a new sample this cycle
- samples  in  NCHAN*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- pre_samples  in  SIZE  pre-trigger window length, latched at arm
- post_samples  in  SIZE  post-trigger window length (trigger sample included), latched at arm
- read_request  in  1  single-cycle pulse that starts readout; honoured only in DONE
- busy  out  1  high in every state except IDLE
- done  out  1  high in DONE only
- trig_missed  out  1  sticky: trigger seen in PRETRIG; cleared by arm
- trig_addr  out  SIZE  buffer address of the first post-trigger sample
- ro_valid / ro_ready  out / in  1  readout handshake
- ro_data  out  WIDTH  sample
- ro_chan  out  CHW  channel of ro_data
- ro_last  out  1  last word of the current channel

## Operation
- States: IDLE, PRETRIG, ARMED, POST, DONE, READOUT.
- Write pointer wp is shared by all channels. It advances by 1 (mod 2^SIZE) on every written sample.
- IDLE: no writes. On arm: latch pre/post, clear fill counter, go to PRETRIG.
- PRETRIG: write every valid sample. Trigger is ignored here and sets trig_missed. Go to ARMED once pre_samples samples have been written (immediately if pre_samples=0).
- ARMED: keep writing, overwriting the oldest data. On trigger: trig_addr ← wp, post counter ← 0, go to POST.
- POST: write valid samples, including one on the trigger cycle itself, until the post counter equals post_samples. Then stop writing and go to DONE. If post_samples=0, nothing is written from the trigger cycle onward.
- Window length L = min(pre+post, 2^SIZE), computed in SIZE+1 bits. Start address S = trig_addr − pre (mod 2^SIZE).
- READOUT: for channel 0..NCHAN-1, emit L words from S, S+1, … (mod 2^SIZE). ro_last is high on the L-th word of each channel. After the last channel's ro_last is accepted, go to IDLE.
- If L=0: read_request → IDLE next cycle, and ro_valid never rises.
- Reset: all state returns to IDLE and every output goes to 0. Buffer contents are undefined and are not cleared.

## Timing
- The state register updates on the clk edge after the qualifying input is sampled.
- First ro_valid appears 2 cycles after read_request, because buffer read is synchronous with 1-cycle latency.
- ro_data, ro_chan and ro_last stay stable while ro_valid && !ro_ready.
- Once the pipeline is full, sustained throughput is 1 word/cycle while ro_ready=1, with no bubble at channel boundaries.
- Simultaneous arm and trigger in IDLE: arm is taken and trigger is ignored.
- A trigger on the same cycle the PRETRIG fill completes is ignored and sets trig_missed. The next trigger is taken.
- arm and read_request outside their own states are ignored. Trigger outside ARMED has no effect, apart from trig_missed in PRETRIG.

## Structure
- The package holds the state enum, the CHW/clog2 helper, and the WIDTH/SIZE defaults.
- Use one sub-module, capture_ringbuf: a simple dual-port RAM of 2^SIZE×WIDTH with a synchronous read. Instantiate it NCHAN times in a generate loop.
- The sequencer, pointers and readout skid register live in the top level.

## Test plan
- NCHAN=2, SIZE=4, pre=3, post=5, ramp data (ch k = 16k+n), trigger after 10 samples → each channel reads 8 words, the trigger sample is the 4th word, ro_last on words 8 and 16.
- pre=12, post=8, SIZE=4 → L clipped to 16, wrap across address 15→0, readout contiguous and correct.
- Trigger pulsed during PRETRIG → trig_missed=1, capture waits for the next trigger; a new arm clears the flag.
- ro_ready toggled randomly → no words lost or duplicated, data held while stalled.
- pre=0, post=0 → read_request returns to IDLE, ro_valid stays 0; post=0 with pre=4 → 4 words per channel, trigger sample excluded.
- reset_n asserted mid-READOUT → outputs 0 immediately; after release, a fresh arm/trigger/readout completes correctly.
